// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier.
// Used by the control/accumulate stage and the Shifter.
package mult_pkg;

  localparam int IN_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CYC0 = 3'd1,
    S_CYC1 = 3'd2,
    S_CYC2 = 3'd3,
    S_CYC3 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] SH_0    = 2'b00;
  localparam logic [1:0] SH_HALF = 2'b01;
  localparam logic [1:0] SH_FULL = 2'b10;

endpackage

// File: rtl/prod_accum.sv
// Product register: load or add the incoming partial product.
// Wraps modulo 2^W; synchronous active-high reset.
module prod_accum #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_add,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_sum;

  assign w_sum = r_q + i_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else if (i_add) begin
      r_q <= w_sum;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mult_seq_accum.sv
// Control-and-accumulate stage of the sequential multiplier.
// Walks the four nibble products and sums the shifted results.
module mult_seq_accum
  import mult_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*IN_W-1:0] shift_out,
  output logic              a_sel,
  output logic              b_sel,
  output logic [1:0]        shift_cntrl,
  output logic [2*IN_W-1:0] product,
  output logic              busy,
  output logic              done
);

  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_add;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = start ? S_CYC0 : S_IDLE;
      S_CYC0:  w_next = S_CYC1;
      S_CYC1:  w_next = S_CYC2;
      S_CYC2:  w_next = S_CYC3;
      S_CYC3:  w_next = S_DONE;
      S_DONE:  w_next = start ? S_CYC0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore decode straight off the state register
  always_comb begin
    a_sel       = 1'b0;
    b_sel       = 1'b0;
    shift_cntrl = SH_0;
    unique case (r_state)
      S_CYC1: begin
        a_sel       = 1'b1;
        shift_cntrl = SH_HALF;
      end
      S_CYC2: begin
        b_sel       = 1'b1;
        shift_cntrl = SH_HALF;
      end
      S_CYC3: begin
        a_sel       = 1'b1;
        b_sel       = 1'b1;
        shift_cntrl = SH_FULL;
      end
      default: begin
        a_sel       = 1'b0;
        b_sel       = 1'b0;
        shift_cntrl = SH_0;
      end
    endcase
  end

  assign w_load = (r_state == S_CYC0);
  assign w_add  = (r_state == S_CYC1) ||
                  (r_state == S_CYC2) ||
                  (r_state == S_CYC3);

  assign busy = w_load || w_add;
  assign done = (r_state == S_DONE);

  prod_accum #(
    .W (2*IN_W)
  ) u_accum (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_add  (w_add),
    .i_d    (shift_out),
    .o_q    (product)
  );

endmodule

// File: tb/tb_mult_seq_accum.sv
// Bench for mult_seq_accum with a behavioural upstream mux,
// 4x4 multiplier and Shifter closing the datapath loop.
module tb_mult_seq_accum;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] shift_out;
  logic        a_sel;
  logic        b_sel;
  logic [1:0]  shift_cntrl;
  logic [15:0] product;
  logic        busy;
  logic        done;

  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [15:0] pp;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[7];

  mult_seq_accum #(.IN_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .shift_out   (shift_out),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .shift_cntrl (shift_cntrl),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    nib_a     = a_sel ? op_a[7:4] : op_a[3:0];
    nib_b     = b_sel ? op_b[7:4] : op_b[3:0];
    pp        = 16'(nib_a) * 16'(nib_b);
    shift_out = pp;
    case (shift_cntrl)
      2'b01:   shift_out = pp << 4;
      2'b10:   shift_out = pp << 8;
      default: shift_out = pp;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One multiply with a one-cycle start; checks select sequence,
  // busy/done shape and the final product against a*b.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string nm);
    logic [3:0] seq [4];
    seq[0] = 4'b00_00;
    seq[1] = 4'b10_01;
    seq[2] = 4'b01_01;
    seq[3] = 4'b11_10;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({nm, " sel"}, {28'd0, a_sel, b_sel, shift_cntrl},
          {28'd0, seq[i]});
      chk({nm, " busy"}, {31'd0, busy | done}, {31'd0, busy});
      @(negedge clk);
    end
    chk({nm, " done"}, {30'd0, done, busy}, 32'd2);
    chk({nm, " prod"}, {16'd0, product}, {16'd0, exp});
    @(negedge clk);
    chk({nm, " idle"}, {30'd0, done, busy}, 32'd0);
    chk({nm, " hold"}, {16'd0, product}, {16'd0, exp});
  endtask

  // Counts busy cycles until done with start held high.
  task automatic held_op(input logic [15:0] exp, input string nm);
    int nb;
    int t;
    nb = 0;
    t  = 0;
    while (!done && t < 12) begin
      if (busy) nb++;
      @(negedge clk);
      t++;
    end
    chk({nm, " done seen"}, {31'd0, done}, 32'd1);
    chk({nm, " busy cycles"}, nb, 32'd4);
    chk({nm, " prod"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int         t;
    logic       seen;
    n_tests = 0;
    n_fail  = 0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    start = 1'b0;
    reset = 1'b1;

    vecs[0] = '{8'h6E, 8'h0F, 16'h0672};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{8'h12, 8'h34, 16'h03A8};
    vecs[4] = '{8'h80, 8'h80, 16'h4000};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[6] = '{8'hF0, 8'h0F, 16'h0E10};

    @(negedge clk);
    @(negedge clk);
    chk("reset prod", {16'd0, product}, 32'd0);
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    chk("reset sel", {28'd0, a_sel, b_sel, shift_cntrl}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle no start", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 7; i++)
      do_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_mul(ra, rb, 16'(ra) * 16'(rb), $sformatf("rnd%0d", i));
    end

    // start held high: back-to-back operation straight from DONE
    op_a  = 8'h6E;
    op_b  = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    held_op(16'h0672, "held1");
    op_a = 8'h12;
    op_b = 8'h34;
    @(negedge clk);
    chk("held restart", {31'd0, busy}, 32'd1);
    held_op(16'h03A8, "held2");
    start = 1'b0;
    @(negedge clk);
    chk("held end idle", {30'd0, busy, done}, 32'd0);
    chk("held end hold", {16'd0, product}, 32'h03A8);

    // reset while in CYC2 throws away the partial sum
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid cyc2 sel", {28'd0, a_sel, b_sel, shift_cntrl}, 32'h5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst prod", {16'd0, product}, 32'd0);
    chk("mid rst busy/done", {30'd0, busy, done}, 32'd0);
    chk("mid rst sel", {28'd0, a_sel, b_sel, shift_cntrl}, 32'd0);
    seen = 1'b0;
    for (t = 0; t < 6; t++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk("mid rst no done", {31'd0, seen}, 32'd0);
    do_mul(8'h6E, 8'h0F, 16'h0672, "after rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
